// File: rtl/keyscan_ctrl_if.sv
// Keypad-side bundle: raw rows in, column strobes, debounced code and strobes out.
interface keyscan_ctrl_if;
    logic [3:0] rows;
    logic [3:0] cols;
    logic [7:0] rcBits;
    logic       key_press;
    logic       key_held;

    modport slave (
        input  rows,
        output cols,
        output rcBits,
        output key_press,
        output key_held
    );

    modport master (
        output rows,
        input  cols,
        input  rcBits,
        input  key_press,
        input  key_held
    );
endinterface

// File: rtl/keyscan_ctrl.sv
// 4x4 keypad scanner: rotating column strobe, 2-flop row sync, press/release debounce.
module keyscan_ctrl #(
    parameter int unsigned SCAN_DIV     = 1000,
    parameter int unsigned DEBOUNCE_CNT = 8
) (
    input  logic          clk,
    input  logic          reset,
    keyscan_ctrl_if.slave bus
);

    localparam int unsigned DW = $clog2(SCAN_DIV);
    localparam int unsigned CW = $clog2(DEBOUNCE_CNT + 1);

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    logic [3:0]    r_rows_m;
    logic [3:0]    r_rows_s;
    logic [DW-1:0] r_dwell;
    state_t        r_state;
    logic [3:0]    r_pat;
    logic [CW-1:0] r_deb_cnt;
    logic [3:0]    r_cols;
    logic [7:0]    r_rcbits;
    logic          r_key_press;
    logic          r_key_held;

    logic          w_sample;
    logic          w_onehot;
    logic [CW-1:0] w_deb_inc;
    logic          w_deb_done;
    logic          w_advance;
    state_t        w_state_nxt;
    logic [3:0]    w_pat_nxt;
    logic [CW-1:0] w_deb_nxt;
    logic [3:0]    w_cols_nxt;
    logic [7:0]    w_rcbits_nxt;
    logic          w_key_press_nxt;
    logic          w_key_held_nxt;

    // Two-flop synchronizer for the asynchronous row lines.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rows_m <= 4'd0;
            r_rows_s <= 4'd0;
        end else begin
            r_rows_m <= bus.rows;
            r_rows_s <= r_rows_m;
        end
    end

    // Free-running dwell counter; its terminal count is the sample point.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_dwell <= '0;
        end else if (r_dwell == DW'(SCAN_DIV - 1)) begin
            r_dwell <= '0;
        end else begin
            r_dwell <= r_dwell + DW'(1);
        end
    end

    assign w_sample   = (r_dwell == DW'(SCAN_DIV - 1));
    assign w_onehot   = (r_rows_s != 4'd0) && ((r_rows_s & (r_rows_s - 4'd1)) == 4'd0);
    assign w_deb_inc  = r_deb_cnt + CW'(1);
    assign w_deb_done = (w_deb_inc == CW'(DEBOUNCE_CNT));

    // State and registered output update.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= SCAN;
            r_pat       <= 4'd0;
            r_deb_cnt   <= '0;
            r_cols      <= 4'b0001;
            r_rcbits    <= 8'd0;
            r_key_press <= 1'b0;
            r_key_held  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pat       <= w_pat_nxt;
            r_deb_cnt   <= w_deb_nxt;
            r_cols      <= w_cols_nxt;
            r_rcbits    <= w_rcbits_nxt;
            r_key_press <= w_key_press_nxt;
            r_key_held  <= w_key_held_nxt;
        end
    end

    // Next-state and output decisions, taken only at sample points.
    always_comb begin
        w_state_nxt     = r_state;
        w_pat_nxt       = r_pat;
        w_deb_nxt       = r_deb_cnt;
        w_cols_nxt      = r_cols;
        w_rcbits_nxt    = r_rcbits;
        w_key_press_nxt = 1'b0;
        w_key_held_nxt  = r_key_held;
        w_advance       = 1'b0;

        if (w_sample) begin
            case (r_state)
                SCAN: begin
                    if (w_onehot) begin
                        w_pat_nxt = r_rows_s;
                        w_deb_nxt = CW'(1);
                        if (DEBOUNCE_CNT == 1) begin
                            w_state_nxt     = HELD;
                            w_rcbits_nxt    = {r_rows_s, r_cols};
                            w_key_held_nxt  = 1'b1;
                            w_key_press_nxt = 1'b1;
                        end else begin
                            w_state_nxt = DEBOUNCE;
                        end
                    end else begin
                        // Idle or ghosted multi-row reading: keep scanning.
                        w_advance = 1'b1;
                    end
                end
                DEBOUNCE: begin
                    if (r_rows_s == r_pat) begin
                        w_deb_nxt = w_deb_inc;
                        if (w_deb_done) begin
                            w_state_nxt     = HELD;
                            w_deb_nxt       = '0;
                            w_rcbits_nxt    = {r_pat, r_cols};
                            w_key_held_nxt  = 1'b1;
                            w_key_press_nxt = 1'b1;
                        end
                    end else begin
                        w_state_nxt = SCAN;
                        w_deb_nxt   = '0;
                        w_advance   = 1'b1;
                    end
                end
                HELD: begin
                    if (r_rows_s == 4'd0) begin
                        if (DEBOUNCE_CNT == 1) begin
                            w_state_nxt    = SCAN;
                            w_deb_nxt      = '0;
                            w_rcbits_nxt   = 8'd0;
                            w_key_held_nxt = 1'b0;
                            w_advance      = 1'b1;
                        end else begin
                            w_state_nxt = RELEASE;
                            w_deb_nxt   = CW'(1);
                        end
                    end
                end
                RELEASE: begin
                    if (r_rows_s == 4'd0) begin
                        w_deb_nxt = w_deb_inc;
                        if (w_deb_done) begin
                            w_state_nxt    = SCAN;
                            w_deb_nxt      = '0;
                            w_rcbits_nxt   = 8'd0;
                            w_key_held_nxt = 1'b0;
                            w_advance      = 1'b1;
                        end
                    end else begin
                        // Release bounce: same key still down, no new press.
                        w_state_nxt = HELD;
                        w_deb_nxt   = '0;
                    end
                end
                default: begin
                    w_state_nxt = SCAN;
                end
            endcase
        end

        if (w_advance) begin
            w_cols_nxt = {r_cols[2:0], r_cols[3]};
        end
    end

    assign bus.cols      = r_cols;
    assign bus.rcBits    = r_rcbits;
    assign bus.key_press = r_key_press;
    assign bus.key_held  = r_key_held;

endmodule

// File: tb/tb_keyscan_ctrl.sv
// Directed bench for keyscan_ctrl with SCAN_DIV=4, DEBOUNCE_CNT=3.
module tb_keyscan_ctrl;

    logic       clk;
    logic       reset;
    logic       key_down;
    logic [3:0] key_row;
    logic [3:0] key_col;
    logic [3:0] force_rows;
    int         edge_n;
    int         n_checks;
    int         n_pass;
    int         press_cnt;
    logic [3:0] exp_c;

    keyscan_ctrl_if bus ();

    keyscan_ctrl #(
        .SCAN_DIV     (4),
        .DEBOUNCE_CNT (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Keypad model: a held key shorts its row onto its column's strobe.
    assign bus.rows = key_down ? (((bus.cols & key_col) != 4'd0) ? key_row : 4'd0)
                               : force_rows;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count every key_press pulse, sampled away from the active edge.
    initial press_cnt = 0;
    always @(negedge clk) if (bus.key_press === 1'b1) press_cnt = press_cnt + 1;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Advance to 1 time unit after the given post-reset clock edge.
    task automatic goto(input int e);
        while (edge_n < e) begin
            @(posedge clk);
            edge_n++;
        end
        #1;
    endtask

    initial begin
        n_checks   = 0;
        n_pass     = 0;
        edge_n     = 0;
        reset      = 1'b0;
        key_down   = 1'b0;
        key_row    = 4'd0;
        key_col    = 4'd0;
        force_rows = 4'd0;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_cols",  8'(bus.cols), 8'h01);
        check("rst_rc",    bus.rcBits, 8'h00);
        check("rst_press", 8'(bus.key_press), 8'h00);
        check("rst_held",  8'(bus.key_held), 8'h00);

        @(negedge clk);
        reset  = 1'b1;
        edge_n = 0;

        // Idle scan: column rotates every 4 clocks, nothing reported.
        for (int e = 1; e <= 40; e++) begin
            goto(e);
            exp_c = 4'b0001 << ((e / 4) % 4);
            check("idle_cols",  8'(bus.cols), 8'(exp_c));
            check("idle_rc",    bus.rcBits, 8'h00);
            check("idle_press", 8'(bus.key_press), 8'h00);
        end

        // Press row 2 on column 1; it reads only while cols==0010 (from edge 52).
        key_row  = 4'b0100;
        key_col  = 4'b0010;
        key_down = 1'b1;
        goto(56);
        check("deb_frozen",  8'(bus.cols), 8'h02);
        goto(63);
        check("deb_nopress", 8'(bus.key_press), 8'h00);
        check("deb_rc0",     bus.rcBits, 8'h00);
        goto(64);
        check("acc_press", 8'(bus.key_press), 8'h01);
        check("acc_rc",    bus.rcBits, 8'h42);
        check("acc_held",  8'(bus.key_held), 8'h01);
        check("acc_cols",  8'(bus.cols), 8'h02);
        goto(65);
        check("acc_pulse1", 8'(bus.key_press), 8'h00);

        // Long hold: no repeat press, column frozen.
        goto(265);
        check("hold_cnt",  8'(press_cnt), 8'd1);
        check("hold_held", 8'(bus.key_held), 8'h01);
        check("hold_rc",   bus.rcBits, 8'h42);
        check("hold_cols", 8'(bus.cols), 8'h02);

        // Clean release: samples at 268, 272, 276 see zero.
        key_down = 1'b0;
        goto(275);
        check("rel_held_pre", 8'(bus.key_held), 8'h01);
        check("rel_rc_pre",   bus.rcBits, 8'h42);
        goto(276);
        check("rel_held", 8'(bus.key_held), 8'h00);
        check("rel_rc",   bus.rcBits, 8'h00);
        check("rel_cols", 8'(bus.cols), 8'h04);

        // Press bounce: one matching sample then zero -> back to scanning.
        force_rows = 4'b0100;
        goto(280);
        check("pb_frozen", 8'(bus.cols), 8'h04);
        force_rows = 4'b0000;
        goto(284);
        check("pb_cols",  8'(bus.cols), 8'h08);
        check("pb_rc",    bus.rcBits, 8'h00);
        check("pb_held",  8'(bus.key_held), 8'h00);
        check("pb_cnt",   8'(press_cnt), 8'd1);

        // Re-acquire 0x42 on column 0010 (strobed from edge 292).
        goto(292);
        check("re_cols", 8'(bus.cols), 8'h02);
        force_rows = 4'b0100;
        goto(304);
        check("re_press", 8'(bus.key_press), 8'h01);
        check("re_rc",    bus.rcBits, 8'h42);

        // Release bounce: two zero samples, then the key returns.
        force_rows = 4'b0000;
        goto(312);
        check("rb_held_mid", 8'(bus.key_held), 8'h01);
        force_rows = 4'b0100;
        goto(316);
        check("rb_press", 8'(bus.key_press), 8'h00);
        goto(320);
        check("rb_held", 8'(bus.key_held), 8'h01);
        check("rb_rc",   bus.rcBits, 8'h42);
        check("rb_cols", 8'(bus.cols), 8'h02);
        check("rb_cnt",  8'(press_cnt), 8'd2);

        // Final release of that key.
        force_rows = 4'b0000;
        goto(331);
        check("fr_held_pre", 8'(bus.key_held), 8'h01);
        goto(332);
        check("fr_held", 8'(bus.key_held), 8'h00);
        check("fr_cols", 8'(bus.cols), 8'h04);

        // Ghost: two rows at once are rejected, scan keeps rotating.
        force_rows = 4'b0011;
        goto(336);
        check("gh_cols1", 8'(bus.cols), 8'h08);
        goto(340);
        check("gh_cols2", 8'(bus.cols), 8'h01);
        check("gh_rc",    bus.rcBits, 8'h00);
        check("gh_held",  8'(bus.key_held), 8'h00);

        // Enter DEBOUNCE on column 0010, then reset asynchronously.
        force_rows = 4'b0000;
        goto(344);
        check("ar_cols_pre", 8'(bus.cols), 8'h02);
        force_rows = 4'b1000;
        goto(348);
        check("ar_frozen", 8'(bus.cols), 8'h02);
        #2;
        reset = 1'b0;
        #1;
        check("ar_cols",  8'(bus.cols), 8'h01);
        check("ar_rc",    bus.rcBits, 8'h00);
        check("ar_press", 8'(bus.key_press), 8'h00);
        check("ar_held",  8'(bus.key_held), 8'h00);

        // Recover from reset: scanning restarts at 0001, no stray press.
        force_rows = 4'b0000;
        @(negedge clk);
        reset  = 1'b1;
        edge_n = 0;
        goto(3);
        check("post_cols0", 8'(bus.cols), 8'h01);
        goto(4);
        check("post_cols1", 8'(bus.cols), 8'h02);
        check("post_cnt",   8'(press_cnt), 8'd2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
